riscv_decode_stage: RTL

RISCV_DECODE_STAGE -- requirements
Module: riscv_decode_stage

---
 rtl/riscv_decode_stage_pkg.sv | 132 +++++++++++++
 rtl/riscv_decoder_core.sv | 154 +++++++++++++++
 rtl/riscv_decode_stage.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/riscv_decode_stage_pkg.sv
// -----------------------------------------------------------------------------
// riscv_decode_stage_pkg
// Shared decode definitions for the RV32I decode stage:
//   - control enums: EXEC_FUN, OP1_SEL, OP2_SEL, WB_SEL, RF_WEN, MEM_WEN,
//     PC_SEL and BR_FUN (each has an _X member used for illegal encodings)
//   - immediate format selector and the packed control bundle carried
//     through the decoded-entry buffer
//   - opcode/funct mask and match constants plus a matching helper
// The M-extension enum members and constants are always present; whether
// they are decoded is controlled by RISCV_M_EXT_EN in riscv_decoder_core.
// -----------------------------------------------------------------------------
package riscv_decode_stage_pkg;

    typedef enum logic [4:0] {
        ALU_X,
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_MUL,
        ALU_MULH,
        ALU_MULHSU,
        ALU_MULHU,
        ALU_DIV,
        ALU_DIVU,
        ALU_REM,
        ALU_REMU
    } exec_fun_e;

    typedef enum logic [1:0] {OP1_X, OP1_RS1, OP1_PC, OP1_ZERO} op1_sel_e;

    typedef enum logic [2:0] {
        OP2_X, OP2_RS2, OP2_IMI, OP2_IMS, OP2_IMB, OP2_IMU, OP2_IMJ
    } op2_sel_e;

    typedef enum logic [1:0] {WB_X, WB_ALU, WB_MEM, WB_PC} wb_sel_e;

    typedef enum logic [1:0] {RF_X, RF_WRITE, RF_NOWRITE} rf_wen_e;

    typedef enum logic [1:0] {MEM_X, MEM_WRITE, MEM_NOWRITE} mem_wen_e;

    typedef enum logic [1:0] {PC_X, PC_PLUS4, PC_B_TARGET, PC_ALU} pc_sel_e;

    typedef enum logic [2:0] {
        BR_X, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU
    } br_fun_e;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_type_e;

    // Width-independent part of a decoded entry; imm and pc are stored
    // separately because their width is a module parameter.
    typedef struct packed {
        exec_fun_e  exec_fun;
        op1_sel_e   op1_sel;
        op2_sel_e   op2_sel;
        wb_sel_e    wb_sel;
        rf_wen_e    rf_wen;
        mem_wen_e   mem_wen;
        pc_sel_e    pc_sel;
        br_fun_e    br_fun;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_ILLEGAL = '{
        exec_fun: ALU_X, op1_sel: OP1_X, op2_sel: OP2_X, wb_sel: WB_X,
        rf_wen: RF_X, mem_wen: MEM_X, pc_sel: PC_X, br_fun: BR_X,
        rs1: 5'd0, rs2: 5'd0, rd: 5'd0, illegal: 1'b1
    };

    // Masks: opcode only, opcode+funct3, opcode+funct3+funct7
    localparam logic [31:0] MASK_OPCODE = 32'h0000_007F;
    localparam logic [31:0] MASK_FUNCT3 = 32'h0000_707F;
    localparam logic [31:0] MASK_FUNCT7 = 32'hFE00_707F;

    localparam logic [31:0] MATCH_LUI    = 32'h0000_0037;
    localparam logic [31:0] MATCH_AUIPC  = 32'h0000_0017;
    localparam logic [31:0] MATCH_JAL    = 32'h0000_006F;
    localparam logic [31:0] MATCH_JALR   = 32'h0000_0067;
    localparam logic [31:0] MATCH_BEQ    = 32'h0000_0063;
    localparam logic [31:0] MATCH_BNE    = 32'h0000_1063;
    localparam logic [31:0] MATCH_BLT    = 32'h0000_4063;
    localparam logic [31:0] MATCH_BGE    = 32'h0000_5063;
    localparam logic [31:0] MATCH_BLTU   = 32'h0000_6063;
    localparam logic [31:0] MATCH_BGEU   = 32'h0000_7063;
    localparam logic [31:0] MATCH_LW     = 32'h0000_2003;
    localparam logic [31:0] MATCH_SW     = 32'h0000_2023;
    localparam logic [31:0] MATCH_ADDI   = 32'h0000_0013;
    localparam logic [31:0] MATCH_SLTI   = 32'h0000_2013;
    localparam logic [31:0] MATCH_SLTIU  = 32'h0000_3013;
    localparam logic [31:0] MATCH_XORI   = 32'h0000_4013;
    localparam logic [31:0] MATCH_ORI    = 32'h0000_6013;
    localparam logic [31:0] MATCH_ANDI   = 32'h0000_7013;
    localparam logic [31:0] MATCH_SLLI   = 32'h0000_1013;
    localparam logic [31:0] MATCH_SRLI   = 32'h0000_5013;
    localparam logic [31:0] MATCH_SRAI   = 32'h4000_5013;
    localparam logic [31:0] MATCH_ADD    = 32'h0000_0033;
    localparam logic [31:0] MATCH_SUB    = 32'h4000_0033;
    localparam logic [31:0] MATCH_SLL    = 32'h0000_1033;
    localparam logic [31:0] MATCH_SLT    = 32'h0000_2033;
    localparam logic [31:0] MATCH_SLTU   = 32'h0000_3033;
    localparam logic [31:0] MATCH_XOR    = 32'h0000_4033;
    localparam logic [31:0] MATCH_SRL    = 32'h0000_5033;
    localparam logic [31:0] MATCH_SRA    = 32'h4000_5033;
    localparam logic [31:0] MATCH_OR     = 32'h0000_6033;
    localparam logic [31:0] MATCH_AND    = 32'h0000_7033;
    localparam logic [31:0] MATCH_MUL    = 32'h0200_0033;
    localparam logic [31:0] MATCH_MULH   = 32'h0200_1033;
    localparam logic [31:0] MATCH_MULHSU = 32'h0200_2033;
    localparam logic [31:0] MATCH_MULHU  = 32'h0200_3033;
    localparam logic [31:0] MATCH_DIV    = 32'h0200_4033;
    localparam logic [31:0] MATCH_DIVU   = 32'h0200_5033;
    localparam logic [31:0] MATCH_REM    = 32'h0200_6033;
    localparam logic [31:0] MATCH_REMU   = 32'h0200_7033;

    function automatic logic is_match(input logic [31:0] inst,
                                      input logic [31:0] mask,
                                      input logic [31:0] match);
        return (inst & mask) == match;
    endfunction

endpackage

// File: rtl/riscv_decoder_core.sv
// -----------------------------------------------------------------------------
// riscv_decoder_core
// Purely combinational RV32I instruction decoder.
// Optional feature macro: RISCV_M_EXT_EN -- when defined, MUL/MULH/MULHSU/
// MULHU/DIV/DIVU/REM/REMU are decoded; otherwise they are flagged illegal.
// Ports:
//   inst  [31:0]          instruction word
//   ctrl  (ctrl_t)        control enums, register fields, illegal flag
//   imm   [WORD_LENGTH]   sign-extended immediate (0 for R-type / illegal)
// -----------------------------------------------------------------------------
module riscv_decoder_core
    import riscv_decode_stage_pkg::*;
#(
    parameter int WORD_LENGTH = 32
) (
    input  logic [31:0]            inst,
    output ctrl_t                  ctrl,
    output logic [WORD_LENGTH-1:0] imm
);

    ctrl_t       dec_ctrl;
    imm_type_e   imm_type;
    logic [31:0] imm32;

    function automatic ctrl_t mk(input exec_fun_e f, input op1_sel_e a,
                                 input op2_sel_e b, input wb_sel_e w,
                                 input rf_wen_e r, input mem_wen_e m,
                                 input pc_sel_e p, input br_fun_e br);
        ctrl_t c;
        c          = CTRL_ILLEGAL;
        c.exec_fun = f;
        c.op1_sel  = a;
        c.op2_sel  = b;
        c.wb_sel   = w;
        c.rf_wen   = r;
        c.mem_wen  = m;
        c.pc_sel   = p;
        c.br_fun   = br;
        c.illegal  = 1'b0;
        return c;
    endfunction

    function automatic ctrl_t r_op(input exec_fun_e f);
        return mk(f, OP1_RS1, OP2_RS2, WB_ALU, RF_WRITE, MEM_NOWRITE, PC_PLUS4, BR_X);
    endfunction

    function automatic ctrl_t i_op(input exec_fun_e f);
        return mk(f, OP1_RS1, OP2_IMI, WB_ALU, RF_WRITE, MEM_NOWRITE, PC_PLUS4, BR_X);
    endfunction

    // Branches compute their target as pc + B-immediate in the ALU.
    function automatic ctrl_t br_op(input br_fun_e b);
        return mk(ALU_ADD, OP1_PC, OP2_IMB, WB_X, RF_NOWRITE, MEM_NOWRITE, PC_B_TARGET, b);
    endfunction

    always_comb begin
        dec_ctrl = CTRL_ILLEGAL;
        imm_type = IMM_NONE;
`ifdef RISCV_M_EXT_EN
        if      (is_match(inst, MASK_FUNCT7, MATCH_MUL))    dec_ctrl = r_op(ALU_MUL);
        else if (is_match(inst, MASK_FUNCT7, MATCH_MULH))   dec_ctrl = r_op(ALU_MULH);
        else if (is_match(inst, MASK_FUNCT7, MATCH_MULHSU)) dec_ctrl = r_op(ALU_MULHSU);
        else if (is_match(inst, MASK_FUNCT7, MATCH_MULHU))  dec_ctrl = r_op(ALU_MULHU);
        else if (is_match(inst, MASK_FUNCT7, MATCH_DIV))    dec_ctrl = r_op(ALU_DIV);
        else if (is_match(inst, MASK_FUNCT7, MATCH_DIVU))   dec_ctrl = r_op(ALU_DIVU);
        else if (is_match(inst, MASK_FUNCT7, MATCH_REM))    dec_ctrl = r_op(ALU_REM);
        else if (is_match(inst, MASK_FUNCT7, MATCH_REMU))   dec_ctrl = r_op(ALU_REMU);
        else
`endif
        if (is_match(inst, MASK_OPCODE, MATCH_LUI)) begin
            dec_ctrl = mk(ALU_ADD, OP1_ZERO, OP2_IMU, WB_ALU, RF_WRITE, MEM_NOWRITE, PC_PLUS4, BR_X);
            imm_type = IMM_U;
        end else if (is_match(inst, MASK_OPCODE, MATCH_AUIPC)) begin
            dec_ctrl = mk(ALU_ADD, OP1_PC, OP2_IMU, WB_ALU, RF_WRITE, MEM_NOWRITE, PC_PLUS4, BR_X);
            imm_type = IMM_U;
        end else if (is_match(inst, MASK_OPCODE, MATCH_JAL)) begin
            dec_ctrl = mk(ALU_ADD, OP1_PC, OP2_IMJ, WB_PC, RF_WRITE, MEM_NOWRITE, PC_ALU, BR_X);
            imm_type = IMM_J;
        end else if (is_match(inst, MASK_FUNCT3, MATCH_JALR)) begin
            dec_ctrl = mk(ALU_ADD, OP1_RS1, OP2_IMI, WB_PC, RF_WRITE, MEM_NOWRITE, PC_ALU, BR_X);
            imm_type = IMM_I;
        end else if (is_match(inst, MASK_FUNCT3, MATCH_BEQ)) begin
            dec_ctrl = br_op(BR_EQ);  imm_type = IMM_B;
        end else if (is_match(inst, MASK_FUNCT3, MATCH_BNE)) begin
            dec_ctrl = br_op(BR_NE);  imm_type = IMM_B;
        end else if (is_match(inst, MASK_FUNCT3, MATCH_BLT)) begin
            dec_ctrl = br_op(BR_LT);  imm_type = IMM_B;
        end else if (is_match(inst, MASK_FUNCT3, MATCH_BGE)) begin
            dec_ctrl = br_op(BR_GE);  imm_type = IMM_B;
        end else if (is_match(inst, MASK_FUNCT3, MATCH_BLTU)) begin
            dec_ctrl = br_op(BR_LTU); imm_type = IMM_B;
        end else if (is_match(inst, MASK_FUNCT3, MATCH_BGEU)) begin
            dec_ctrl = br_op(BR_GEU); imm_type = IMM_B;
        end else if (is_match(inst, MASK_FUNCT3, MATCH_LW)) begin
            dec_ctrl = mk(ALU_ADD, OP1_RS1, OP2_IMI, WB_MEM, RF_WRITE, MEM_NOWRITE, PC_PLUS4, BR_X);
            imm_type = IMM_I;
        end else if (is_match(inst, MASK_FUNCT3, MATCH_SW)) begin
            dec_ctrl = mk(ALU_ADD, OP1_RS1, OP2_IMS, WB_X, RF_NOWRITE, MEM_WRITE, PC_PLUS4, BR_X);
            imm_type = IMM_S;
        end else if (is_match(inst, MASK_FUNCT3, MATCH_ADDI)) begin
            dec_ctrl = i_op(ALU_ADD);  imm_type = IMM_I;
        end else if (is_match(inst, MASK_FUNCT3, MATCH_SLTI)) begin
            dec_ctrl = i_op(ALU_SLT);  imm_type = IMM_I;
        end else if (is_match(inst, MASK_FUNCT3, MATCH_SLTIU)) begin
            dec_ctrl = i_op(ALU_SLTU); imm_type = IMM_I;
        end else if (is_match(inst, MASK_FUNCT3, MATCH_XORI)) begin
            dec_ctrl = i_op(ALU_XOR);  imm_type = IMM_I;
        end else if (is_match(inst, MASK_FUNCT3, MATCH_ORI)) begin
            dec_ctrl = i_op(ALU_OR);   imm_type = IMM_I;
        end else if (is_match(inst, MASK_FUNCT3, MATCH_ANDI)) begin
            dec_ctrl = i_op(ALU_AND);  imm_type = IMM_I;
        end else if (is_match(inst, MASK_FUNCT7, MATCH_SLLI)) begin
            dec_ctrl = i_op(ALU_SLL);  imm_type = IMM_I;
        end else if (is_match(inst, MASK_FUNCT7, MATCH_SRLI)) begin
            dec_ctrl = i_op(ALU_SRL);  imm_type = IMM_I;
        end else if (is_match(inst, MASK_FUNCT7, MATCH_SRAI)) begin
            dec_ctrl = i_op(ALU_SRA);  imm_type = IMM_I;
        end
        else if (is_match(inst, MASK_FUNCT7, MATCH_ADD))  dec_ctrl = r_op(ALU_ADD);
        else if (is_match(inst, MASK_FUNCT7, MATCH_SUB))  dec_ctrl = r_op(ALU_SUB);
        else if (is_match(inst, MASK_FUNCT7, MATCH_SLL))  dec_ctrl = r_op(ALU_SLL);
        else if (is_match(inst, MASK_FUNCT7, MATCH_SLT))  dec_ctrl = r_op(ALU_SLT);
        else if (is_match(inst, MASK_FUNCT7, MATCH_SLTU)) dec_ctrl = r_op(ALU_SLTU);
        else if (is_match(inst, MASK_FUNCT7, MATCH_XOR))  dec_ctrl = r_op(ALU_XOR);
        else if (is_match(inst, MASK_FUNCT7, MATCH_SRL))  dec_ctrl = r_op(ALU_SRL);
        else if (is_match(inst, MASK_FUNCT7, MATCH_SRA))  dec_ctrl = r_op(ALU_SRA);
        else if (is_match(inst, MASK_FUNCT7, MATCH_OR))   dec_ctrl = r_op(ALU_OR);
        else if (is_match(inst, MASK_FUNCT7, MATCH_AND))  dec_ctrl = r_op(ALU_AND);
    end

    // Build every format as a 32-bit sign-correct value, then widen once.
    always_comb begin
        imm32 = 32'd0;
        case (imm_type)
            IMM_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm32 = {inst[31:12], 12'd0};
            IMM_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm32 = 32'd0;
        endcase
    end

    assign imm = WORD_LENGTH'($signed(imm32));

    // Register fields are passed through raw for every encoding.
    always_comb begin
        ctrl     = dec_ctrl;
        ctrl.rs1 = inst[19:15];
        ctrl.rs2 = inst[24:20];
        ctrl.rd  = inst[11:7];
    end

endmodule

// File: rtl/riscv_decode_stage.sv
// -----------------------------------------------------------------------------
// riscv_decode_stage
// Decode stage: decodes each accepted instruction through riscv_decoder_core
// and queues the result in a QUEUE_DEPTH-entry buffer toward execute.
// Optional feature macro: RISCV_M_EXT_EN (handled inside riscv_decoder_core).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        fetch handshake; in_ready = buffer not full
//   inst, pc_i               instruction and its address
//   flush                    drops all buffered entries and same-cycle input
//   out_valid/out_ready      execute handshake
//   exec_fun..pc_sel, br_fun control enums of the head entry
//   rs1, rs2, rd, imm, pc_o  register fields, immediate, address of head
//   illegal_o                head entry was not a recognised encoding
// -----------------------------------------------------------------------------
module riscv_decode_stage
    import riscv_decode_stage_pkg::*;
#(
    parameter int WORD_LENGTH = 32,
    parameter int QUEUE_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            inst,
    input  logic [WORD_LENGTH-1:0] pc_i,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output exec_fun_e              exec_fun,
    output op1_sel_e               op1_sel,
    output op2_sel_e               op2_sel,
    output wb_sel_e                wb_sel,
    output rf_wen_e                rf_wen,
    output mem_wen_e               mem_wen,
    output pc_sel_e                pc_sel,
    output br_fun_e                br_fun,
    output logic [4:0]             rs1,
    output logic [4:0]             rs2,
    output logic [4:0]             rd,
    output logic [WORD_LENGTH-1:0] imm,
    output logic [WORD_LENGTH-1:0] pc_o,
    output logic                   illegal_o
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    ctrl_t                  dec_ctrl;
    logic [WORD_LENGTH-1:0] dec_imm;

    riscv_decoder_core #(
        .WORD_LENGTH(WORD_LENGTH)
    ) u_decoder_core (
        .inst(inst),
        .ctrl(dec_ctrl),
        .imm (dec_imm)
    );

    // Entry storage; never reset, validity is tracked by count_reg alone.
    ctrl_t                  ctrl_mem [QUEUE_DEPTH];
    logic [WORD_LENGTH-1:0] imm_mem  [QUEUE_DEPTH];
    logic [WORD_LENGTH-1:0] pc_mem   [QUEUE_DEPTH];

    logic [PTR_W-1:0]       wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]       rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]       count_reg, count_next;
    logic                   full, empty, push, pop;
    logic [QUEUE_DEPTH-1:0] slot_we;
    ctrl_t                  head_ctrl;

    assign full      = (count_reg == CNT_W'(QUEUE_DEPTH));
    assign empty     = (count_reg == '0);
    // in_ready is purely a function of occupancy, never of out_ready.
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && !full && !flush;
    assign pop       = !empty && out_ready && !flush;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            // Power-of-two depth: pointers wrap by natural overflow.
            wr_ptr_next = wr_ptr_reg + PTR_W'(push);
            rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
            count_next  = count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_slot_we
            assign slot_we[gi] = push && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (slot_we[i]) begin
                ctrl_mem[i] <= dec_ctrl;
                imm_mem[i]  <= dec_imm;
                pc_mem[i]   <= pc_i;
            end
        end
    end

    // Head is held until popped, so outputs are stable under back-pressure.
    assign head_ctrl = ctrl_mem[rd_ptr_reg];
    assign exec_fun  = head_ctrl.exec_fun;
    assign op1_sel   = head_ctrl.op1_sel;
    assign op2_sel   = head_ctrl.op2_sel;
    assign wb_sel    = head_ctrl.wb_sel;
    assign rf_wen    = head_ctrl.rf_wen;
    assign mem_wen   = head_ctrl.mem_wen;
    assign pc_sel    = head_ctrl.pc_sel;
    assign br_fun    = head_ctrl.br_fun;
    assign rs1       = head_ctrl.rs1;
    assign rs2       = head_ctrl.rs2;
    assign rd        = head_ctrl.rd;
    assign illegal_o = head_ctrl.illegal;
    assign imm       = imm_mem[rd_ptr_reg];
    assign pc_o      = pc_mem[rd_ptr_reg];

endmodule
